// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, and drives a
// variable-latency request/ready instruction-memory handshake.
// Optional build macro IF_FETCH_PERF_EN adds fetch_cnt/drop_cnt counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_Wr_en,
  input  logic        IF_ID_Wr_en,
  input  logic        IF_ID_flush,
  input  logic        Branch_hazard,
  input  logic [31:0] Branch_target,
  input  logic        Jump_en,
  input  logic [31:0] Jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_plus4,
  output logic        IF_ID_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt
`endif
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   hold_q, hold_d;
  logic [XLEN-1:0]   stale_q, stale_d;
  logic [XLEN-1:0]   instr_d, pc4_d;
  logic              valid_d;

  logic              redirect;
  logic [XLEN-1:0]   target;
  logic              have;
  logic [XLEN-1:0]   word;
  logic              accept;
  logic              discard;
  logic [XLEN-1:0]   pc_plus4;

  // Handshake qualifiers; Branch_hazard outranks Jump_en.
  assign redirect = Branch_hazard | Jump_en;
  assign target   = Branch_hazard ? Branch_target : Jump_target;
  assign have     = ((state_q == S_WAIT) && imem_ready) || (state_q == S_HOLD);
  assign word     = (state_q == S_HOLD) ? hold_q : imem_rdata;
  assign accept   = have && IF_ID_Wr_en && PC_Wr_en && !redirect;
  assign discard  = (have && redirect) || ((state_q == S_DROP) && imem_ready);
  assign pc_plus4 = pc_q + XLEN'(4);

  // Memory request depends only on state and stored addresses, never on ready.
  assign imem_req  = (state_q == S_WAIT) || (state_q == S_DROP);
  assign imem_addr = (state_q == S_DROP) ? stale_q : pc_q;

  // Next-state, PC, hold-buffer and IF/ID next-value logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    stale_d = stale_q;
    instr_d = '0;
    pc4_d   = '0;
    valid_d = 1'b0;

    case (state_q)
      S_START: begin
        state_d = S_WAIT;
        if (redirect) pc_d = target;
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = target;
          if (!imem_ready) begin
            // Request cannot be withdrawn; remember its address and discard it.
            state_d = S_DROP;
            stale_d = pc_q;
          end
        end else if (accept) begin
          pc_d = pc_plus4;
        end else if (imem_ready) begin
          hold_d  = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_WAIT;
        end else if (accept) begin
          pc_d    = pc_plus4;
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (redirect) pc_d = target;
        if (imem_ready) state_d = S_WAIT;
      end
      default: state_d = S_START;
    endcase

    if (IF_ID_flush) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!IF_ID_Wr_en) begin
      instr_d = IF_ID_Instruction;
      pc4_d   = IF_ID_PC_plus4;
      valid_d = IF_ID_valid;
    end else if (accept) begin
      instr_d = word;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // State, PC, buffers and IF/ID register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= S_START;
      pc_q              <= RESET_PC;
      hold_q            <= '0;
      stale_q           <= '0;
      IF_ID_Instruction <= '0;
      IF_ID_PC_plus4    <= '0;
      IF_ID_valid       <= 1'b0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      hold_q            <= hold_d;
      stale_q           <= stale_d;
      IF_ID_Instruction <= instr_d;
      IF_ID_PC_plus4    <= pc4_d;
      IF_ID_valid       <= valid_d;
    end
  end

`ifdef IF_FETCH_PERF_EN
  // Wrapping counters of accepted and discarded instruction words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + XLEN'(accept);
      drop_cnt  <= drop_cnt + XLEN'(discard);
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal
// expectations, then randomized control/latency stimulus against a
// behavioural fetch model. Define IF_FETCH_PERF_EN to check the counters.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        PC_Wr_en, IF_ID_Wr_en, IF_ID_flush;
  logic        Branch_hazard, Jump_en;
  logic [31:0] Branch_target, Jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_Instruction, IF_ID_PC_plus4;
  logic        IF_ID_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt, drop_cnt;
`endif

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .PC_Wr_en(PC_Wr_en), .IF_ID_Wr_en(IF_ID_Wr_en), .IF_ID_flush(IF_ID_flush),
    .Branch_hazard(Branch_hazard), .Branch_target(Branch_target),
    .Jump_en(Jump_en), .Jump_target(Jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC_plus4(IF_ID_PC_plus4),
    .IF_ID_valid(IF_ID_valid)
`ifdef IF_FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: is fetching live, is a word parked, is a stale request
  // outstanding, and what the IF/ID register must hold.
  bit          m_started, m_held, m_stale;
  logic [31:0] m_pc, m_hword, m_stale_addr;
  logic [31:0] m_instr, m_pc4;
  bit          m_valid;
  logic [31:0] m_fetch, m_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_req();
    return m_started && !m_held;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic compare_all();
    check("imem_req", 32'(imem_req), 32'(exp_req()));
    check("imem_addr", imem_addr, exp_addr());
    check("IF_ID_Instruction", IF_ID_Instruction, m_instr);
    check("IF_ID_PC_plus4", IF_ID_PC_plus4, m_pc4);
    check("IF_ID_valid", 32'(IF_ID_valid), 32'(m_valid));
`ifdef IF_FETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("drop_cnt", drop_cnt, m_drop);
`endif
  endtask

  // One clock: drive inputs just after a falling edge, advance the model,
  // then compare everything after the next falling edge.
  task automatic step(input bit rst, input bit pwe, input bit iwe, input bit fl,
                      input bit br, input logic [31:0] bt,
                      input bit jen, input logic [31:0] jt,
                      input bit rdy, input logic [31:0] salt);
    logic [31:0] rdata;
    bit req, got, have, redir, acc;
    logic [31:0] wrd, tgt;
    req   = exp_req();
    rdata = rdy ? (exp_addr() ^ salt) : $urandom;
    rst_n = rst; PC_Wr_en = pwe; IF_ID_Wr_en = iwe; IF_ID_flush = fl;
    Branch_hazard = br; Branch_target = bt; Jump_en = jen; Jump_target = jt;
    imem_ready = rdy; imem_rdata = rdata;

    if (!rst) begin
      m_started = 0; m_held = 0; m_stale = 0; m_pc = 32'h0;
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_fetch = 0; m_drop = 0;
    end else begin
      got   = req && rdy && !m_stale;
      have  = got || m_held;
      wrd   = m_held ? m_hword : rdata;
      redir = br || jen;
      tgt   = br ? bt : jt;
      acc   = have && iwe && pwe && !redir;
      if (fl) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (iwe) begin
        if (acc) begin m_instr = wrd; m_pc4 = m_pc + 32'd4; m_valid = 1; end
        else begin m_instr = 0; m_pc4 = 0; m_valid = 0; end
      end
      if (!m_started) begin
        m_started = 1;
        if (redir) m_pc = tgt;
      end else if (m_stale) begin
        if (redir) m_pc = tgt;
        if (rdy) begin m_stale = 0; m_drop++; end
      end else if (redir) begin
        if (have) m_drop++;
        if (!m_held && !rdy) begin m_stale = 1; m_stale_addr = m_pc; end
        m_held = 0;
        m_pc = tgt;
      end else if (acc) begin
        m_pc = m_pc + 32'd4; m_held = 0; m_fetch++;
      end else if (got) begin
        m_held = 1; m_hword = rdata;
      end
    end

    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Plain sequential step with all enables high and no redirect.
  task automatic run(input bit rdy);
    step(1, 1, 1, 0, 0, 32'h0, 0, 32'h0, rdy, 32'h0);
  endtask

  initial begin
    rst_n = 0; PC_Wr_en = 1; IF_ID_Wr_en = 1; IF_ID_flush = 0;
    Branch_hazard = 0; Branch_target = 0; Jump_en = 0; Jump_target = 0;
    imem_ready = 0; imem_rdata = 0;
    @(negedge clk);

    // Reset
    step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check("lit reset req", 32'(imem_req), 32'h0);
    check("lit reset addr", imem_addr, 32'h0);
    check("lit reset valid", 32'(IF_ID_valid), 32'h0);

    // Stream at one per cycle, rdata = address
    run(1);
    check("lit first req", 32'(imem_req), 32'h1);
    check("lit first addr", imem_addr, 32'h0);
    run(1);
    check("lit s0 instr", IF_ID_Instruction, 32'h0);
    check("lit s0 pc4", IF_ID_PC_plus4, 32'h4);
    check("lit s0 valid", 32'(IF_ID_valid), 32'h1);
    run(1);
    check("lit s1 pc4", IF_ID_PC_plus4, 32'h8);
    check("lit s1 addr", imem_addr, 32'h8);

    // Load-use stall while word@0x8 returns
    step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h0);
    check("lit stall req", 32'(imem_req), 32'h0);
    check("lit stall pc4", IF_ID_PC_plus4, 32'h8);
    step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check("lit stall2 instr", IF_ID_Instruction, 32'h4);
    run(0);
    check("lit release instr", IF_ID_Instruction, 32'h8);
    check("lit release pc4", IF_ID_PC_plus4, 32'hC);
    check("lit release addr", imem_addr, 32'hC);
    check("lit release req", 32'(imem_req), 32'h1);
    run(1);
    check("lit req 0x10", imem_addr, 32'h10);

    // Branch in cycle 1 of a 3-cycle request to 0x10
    step(1, 1, 1, 0, 1, 32'h100, 0, 32'h0, 0, 32'h0);
    check("lit drop addr", imem_addr, 32'h10);
    check("lit drop valid", 32'(IF_ID_valid), 32'h0);
    run(0);
    check("lit drop addr2", imem_addr, 32'h10);
    run(1);
    check("lit after drop addr", imem_addr, 32'h100);
    check("lit after drop valid", 32'(IF_ID_valid), 32'h0);
`ifdef IF_FETCH_PERF_EN
    check("lit drop_cnt", drop_cnt, 32'd1);
    check("lit fetch_cnt", fetch_cnt, 32'd4);
`endif
    run(1);
    check("lit target pc4", IF_ID_PC_plus4, 32'h104);

    // Branch and jump together with flush
    step(1, 1, 1, 1, 1, 32'h200, 1, 32'h300, 1, 32'h0);
    check("lit prio addr", imem_addr, 32'h200);
    check("lit prio valid", 32'(IF_ID_valid), 32'h0);
    check("lit prio instr", IF_ID_Instruction, 32'h0);

    // Reset while in DROP
    step(1, 1, 1, 0, 1, 32'h400, 0, 32'h0, 0, 32'h0);
    check("lit drop2 addr", imem_addr, 32'h200);
    step(0, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    check("lit rst req", 32'(imem_req), 32'h0);
    check("lit rst addr", imem_addr, 32'h0);
    run(1);
    check("lit restart addr", imem_addr, 32'h0);
    check("lit restart valid", 32'(IF_ID_valid), 32'h0);
    run(1);
    check("lit restart pc4", IF_ID_PC_plus4, 32'h4);
    check("lit restart valid2", 32'(IF_ID_valid), 32'h1);

    // Randomized controls and memory latency
    for (int i = 0; i < 4000; i++) begin
      bit r_rst, r_pwe, r_iwe, r_fl, r_br, r_jen, r_rdy;
      logic [31:0] r_bt, r_jt, r_salt;
      r_rst  = ($urandom_range(0, 79) != 0);
      r_pwe  = ($urandom_range(0, 5) != 0);
      r_iwe  = r_pwe ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      r_fl   = ($urandom_range(0, 9) == 0);
      r_br   = ($urandom_range(0, 11) == 0);
      r_jen  = ($urandom_range(0, 9) == 0);
      r_bt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      r_jt   = $urandom & 32'hFFFF_FFFC;
      r_rdy  = (exp_req() || !m_started) ? ($urandom_range(0, 99) < 55) : 1'b0;
      r_salt = $urandom;
      step(r_rst, r_pwe, r_iwe, r_fl, r_br, r_bt, r_jen, r_jt, r_rdy, r_salt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
